// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcodes, ALU funcs, FSM states
// and instruction field positions derived from the top-level parameters.
package simple_cpu_pkg;

    localparam int OP_W   = 2;
    localparam int FUNC_W = 4;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [3:0] F_ADD = 4'd0;
    localparam logic [3:0] F_SUB = 4'd1;
    localparam logic [3:0] F_AND = 4'd2;
    localparam logic [3:0] F_OR  = 4'd3;
    localparam logic [3:0] F_XOR = 4'd4;
    localparam logic [3:0] F_SLT = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    // Layout, MSB first: opcode | X1 | X2 | X3 | imm | func
    function automatic int imm_width(input int instr_w, input int reg_bits);
        return instr_w - OP_W - 3 * reg_bits - FUNC_W;
    endfunction

    function automatic int x3_lsb(input int instr_w, input int reg_bits);
        return FUNC_W + imm_width(instr_w, reg_bits);
    endfunction

    function automatic int x2_lsb(input int instr_w, input int reg_bits);
        return x3_lsb(instr_w, reg_bits) + reg_bits;
    endfunction

    function automatic int x1_lsb(input int instr_w, input int reg_bits);
        return x2_lsb(instr_w, reg_bits) + reg_bits;
    endfunction

    function automatic int op_lsb(input int instr_w, input int reg_bits);
        return x1_lsb(instr_w, reg_bits) + reg_bits;
    endfunction

endpackage

// File: rtl/simple_cpu_mc_alu.sv
// Combinational ALU: unsigned add/sub with carry/borrow, bitwise ops and
// unsigned set-less-than; funcs outside 0..5 are flagged illegal.
module cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [3:0]            func,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry,
    output logic                  zero,
    output logic                  illegal
);

    logic [DATA_WIDTH:0] sum;

    always_comb begin
        sum     = '0;
        result  = '0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (func)
            F_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[DATA_WIDTH-1:0];
                carry  = sum[DATA_WIDTH];
            end
            // The extra top bit of the widened difference is the borrow.
            F_SUB: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[DATA_WIDTH-1:0];
                carry  = sum[DATA_WIDTH];
            end
            F_AND:   result = a & b;
            F_OR:    result = a | b;
            F_XOR:   result = a ^ b;
            F_SLT:   result = DATA_WIDTH'(a < b);
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/simple_cpu_mc.sv
// Multi-cycle CPU: one instruction at a time over valid/ready, with an inline
// register file and data memory, plus combinational debug read ports.
//
// state  | meaning
// IDLE   | instr_ready high; latch instruction on instr_valid
// DECODE | read X1/X2/X3 register values into holding flops
// EXEC   | ALU result or effective address; LOADI/ALU -> WB, LOAD/STORE -> MEM
// MEM    | LOAD captures dmem[addr]; STORE writes dmem on the exit edge
// WB     | done (and illegal) high; regfile and flags written on the exit edge
module simple_cpu_mc
    import simple_cpu_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_BITS   = 5,
    parameter int INSTR_WIDTH = 20,
    parameter int REG_BITS    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   done,
    output logic                   illegal,
    output logic                   zero_flag,
    output logic                   carry_flag,
    input  logic [REG_BITS-1:0]    dbg_reg_sel,
    output logic [DATA_WIDTH-1:0]  dbg_reg_data,
    input  logic [ADDR_BITS-1:0]   dbg_mem_addr,
    output logic [DATA_WIDTH-1:0]  dbg_mem_data
);

    localparam int IMM_W  = imm_width(INSTR_WIDTH, REG_BITS);
    localparam int X3_LSB = x3_lsb(INSTR_WIDTH, REG_BITS);
    localparam int X2_LSB = x2_lsb(INSTR_WIDTH, REG_BITS);
    localparam int X1_LSB = x1_lsb(INSTR_WIDTH, REG_BITS);
    localparam int OP_LSB = op_lsb(INSTR_WIDTH, REG_BITS);
    localparam int NREGS  = 2 ** REG_BITS;
    localparam int DEPTH  = 2 ** ADDR_BITS;

    if (INSTR_WIDTH < OP_W + 3 * REG_BITS + FUNC_W + ADDR_BITS) begin : g_bad_cfg
        $error("simple_cpu_mc: INSTR_WIDTH too small for register and address fields");
    end

    state_e                  state_q, state_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic [ADDR_BITS-1:0]    addr_q, addr_d;
    logic                    alu_carry_q, alu_carry_d, alu_zero_q, alu_zero_d;
    logic                    ready_q, ready_d, done_q, done_d, illegal_q, illegal_d;
    logic                    zero_flag_q, zero_flag_d, carry_flag_q, carry_flag_d;

    logic [DATA_WIDTH-1:0]   regs_q [NREGS];
    logic [DATA_WIDTH-1:0]   dmem_q [DEPTH];

    logic                    reg_we, mem_we;
    logic [REG_BITS-1:0]     reg_waddr;
    logic [DATA_WIDTH-1:0]   reg_wdata;

    logic [1:0]              f_op;
    logic [REG_BITS-1:0]     f_x1, f_x2, f_x3;
    logic [IMM_W-1:0]        f_imm;
    logic [3:0]              f_func;

    logic [DATA_WIDTH-1:0]   alu_result;
    logic                    alu_carry, alu_zero, alu_illegal;

    assign f_op   = instr_q[OP_LSB +: OP_W];
    assign f_x1   = instr_q[X1_LSB +: REG_BITS];
    assign f_x2   = instr_q[X2_LSB +: REG_BITS];
    assign f_x3   = instr_q[X3_LSB +: REG_BITS];
    assign f_imm  = instr_q[FUNC_W +: IMM_W];
    assign f_func = instr_q[0 +: FUNC_W];

    cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .a       (x2_q),
        .b       (x3_q),
        .func    (f_func),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero),
        .illegal (alu_illegal)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        x1_d         = x1_q;
        x2_d         = x2_q;
        x3_d         = x3_q;
        res_d        = res_q;
        addr_d       = addr_q;
        alu_carry_d  = alu_carry_q;
        alu_zero_d   = alu_zero_q;
        ready_d      = 1'b0;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        zero_flag_d  = zero_flag_q;
        carry_flag_d = carry_flag_q;
        reg_we       = 1'b0;
        reg_waddr    = f_x1;
        reg_wdata    = res_q;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (instr_valid && ready_q) begin
                    instr_d = instruction;
                    state_d = S_DECODE;
                    ready_d = 1'b0;
                end
            end
            S_DECODE: begin
                x1_d    = regs_q[f_x1];
                x2_d    = regs_q[f_x2];
                x3_d    = regs_q[f_x3];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                res_d       = alu_result;
                alu_carry_d = alu_carry;
                alu_zero_d  = alu_zero;
                addr_d      = ADDR_BITS'(x2_q) + ADDR_BITS'(f_imm);
                if (f_op == OP_LOADI || f_op == OP_ALU) begin
                    state_d   = S_WB;
                    done_d    = 1'b1;
                    illegal_d = (f_op == OP_ALU) && alu_illegal;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                if (f_op == OP_LOAD) begin
                    res_d = dmem_q[addr_q];
                end else begin
                    mem_we = 1'b1;
                end
                state_d = S_WB;
                done_d  = 1'b1;
            end
            S_WB: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                case (f_op)
                    OP_LOADI: begin
                        reg_we    = 1'b1;
                        reg_wdata = DATA_WIDTH'(f_imm);
                    end
                    // illegal_q is high exactly when this WB belongs to a bad func.
                    OP_ALU: begin
                        if (!illegal_q) begin
                            reg_we       = 1'b1;
                            zero_flag_d  = alu_zero_q;
                            carry_flag_d = alu_carry_q;
                        end
                    end
                    OP_LOAD:  reg_we = 1'b1;
                    default:  reg_we = 1'b0;
                endcase
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            instr_q      <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            x3_q         <= '0;
            res_q        <= '0;
            addr_q       <= '0;
            alu_carry_q  <= 1'b0;
            alu_zero_q   <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= DATA_WIDTH'(i);
            for (int i = 0; i < DEPTH; i++) dmem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            x1_q         <= x1_d;
            x2_q         <= x2_d;
            x3_q         <= x3_d;
            res_q        <= res_d;
            addr_q       <= addr_d;
            alu_carry_q  <= alu_carry_d;
            alu_zero_q   <= alu_zero_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
            zero_flag_q  <= zero_flag_d;
            carry_flag_q <= carry_flag_d;
            if (reg_we) regs_q[reg_waddr] <= reg_wdata;
            if (mem_we) dmem_q[addr_q] <= x1_q;
        end
    end

    assign instr_ready  = ready_q;
    assign done         = done_q;
    assign illegal      = illegal_q;
    assign zero_flag    = zero_flag_q;
    assign carry_flag   = carry_flag_q;
    assign dbg_reg_data = regs_q[dbg_reg_sel];
    assign dbg_mem_data = dmem_q[dbg_mem_addr];

endmodule
